// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// bus widths, FSM state encoding, grant-history encoding and the
// contention tie-break helper.
package wb_arb_pkg;

  localparam int WB_ADDR_W = 30;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  // Arbiter FSM states: idle or bus owned by master A / master B.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  // Encoding of the last_grant history bit.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  // Returns 1 when B should be granted from IDLE: B alone, or both
  // requesting and A was the most recent owner.
  function automatic logic pick_b(input logic a_cyc,
                                  input logic b_cyc,
                                  input logic last_grant);
    pick_b = b_cyc & (~a_cyc | (last_grant == LAST_A));
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog for the arbiter. Counts clocks while enabled; o_expire is a
// single-cycle pulse during the TIMEOUT_CYCLES-th consecutive enabled clock.
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen during the final enabled clock before expiry.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_r;

  assign o_expire = i_enable & (count_r == LAST_CNT);

  // Stalled-cycle counter: cleared by responses/idle, restarts after expiry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (o_expire) begin
      count_r <= {CNT_W{1'b0}};
    end else if (i_enable) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone (pipelined) round-robin arbiter onto one shared bus.
// The grant is held while the owner keeps cyc high (no preemption); there
// is always one IDLE clock between grants. The slave-side path is a
// combinational mux selected by the registered grant state.
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that errors
// the owner and drops the bus when the slave fails to respond within
// TIMEOUT_CYCLES clocks.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  // master A
  input  logic                 i_a_cyc,
  input  logic                 i_a_stb,
  input  logic                 i_a_we,
  input  logic [WB_ADDR_W-1:0] i_a_addr,
  input  logic [WB_DATA_W-1:0] i_a_data,
  input  logic [WB_SEL_W-1:0]  i_a_sel,
  output logic                 o_a_stall,
  output logic                 o_a_ack,
  output logic                 o_a_err,
  output logic [WB_DATA_W-1:0] o_a_data,
  // master B
  input  logic                 i_b_cyc,
  input  logic                 i_b_stb,
  input  logic                 i_b_we,
  input  logic [WB_ADDR_W-1:0] i_b_addr,
  input  logic [WB_DATA_W-1:0] i_b_data,
  input  logic [WB_SEL_W-1:0]  i_b_sel,
  output logic                 o_b_stall,
  output logic                 o_b_ack,
  output logic                 o_b_err,
  output logic [WB_DATA_W-1:0] o_b_data,
  // shared slave bus
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [WB_ADDR_W-1:0] o_wb_addr,
  output logic [WB_DATA_W-1:0] o_wb_data,
  output logic [WB_SEL_W-1:0]  o_wb_sel,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err,
  input  logic [WB_DATA_W-1:0] i_wb_data
);

  // A zero watchdog limit cannot produce a meaningful expiry.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("wb_rr_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       last_grant_r;
  logic       last_grant_nxt_s;
  logic       abort_s;
  logic       wd_expire_s;
  logic       own_cyc_s;
  logic       bus_cyc_s;

  // Next-state and round-robin history update.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (i_a_cyc || i_b_cyc) begin
          if (pick_b(i_a_cyc, i_b_cyc, last_grant_r)) begin
            state_nxt_s      = GNT_B;
            last_grant_nxt_s = LAST_B;
          end else begin
            state_nxt_s      = GNT_A;
            last_grant_nxt_s = LAST_A;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_A: begin
        if (i_a_cyc) begin
          state_nxt_s = GNT_A;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_B: begin
        if (i_b_cyc) begin
          state_nxt_s = GNT_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Grant state and history registers; reset makes A win first contention.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_B;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Owner's bus-cycle request, gated by a pending watchdog abort.
  always_comb begin
    own_cyc_s = 1'b0;
    case (state_r)
      GNT_A:   own_cyc_s = i_a_cyc;
      GNT_B:   own_cyc_s = i_b_cyc;
      default: own_cyc_s = 1'b0;
    endcase
    bus_cyc_s = own_cyc_s & ~abort_s;
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic abort_r;
  logic wd_enable_s;
  logic wd_clear_s;

  assign wd_enable_s = bus_cyc_s & ~i_wb_ack & ~i_wb_err;
  assign wd_clear_s  = (state_r == IDLE) | i_wb_ack | i_wb_err;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(wd_enable_s),
    .i_clear (wd_clear_s),
    .o_expire(wd_expire_s)
  );

  // Abort latches on expiry and holds the bus off until the grant ends.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      abort_r <= 1'b0;
    end else if (state_nxt_s == IDLE) begin
      abort_r <= 1'b0;
    end else if (wd_expire_s) begin
      abort_r <= 1'b1;
    end else begin
      abort_r <= abort_r;
    end
  end

  assign abort_s = abort_r;
`else
  // Without the watchdog a hung slave simply keeps the grant.
  assign abort_s     = 1'b0;
  assign wd_expire_s = 1'b0;
`endif

  // Read data goes to both masters; only the owner sees ack/err.
  assign o_a_data = i_wb_data;
  assign o_b_data = i_wb_data;

  // Shared-bus mux and response routing for the current owner.
  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = {WB_ADDR_W{1'b0}};
    o_wb_data = {WB_DATA_W{1'b0}};
    o_wb_sel  = {WB_SEL_W{1'b0}};
    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    case (state_r)
      GNT_A: begin
        o_wb_cyc  = bus_cyc_s;
        o_wb_stb  = i_a_stb & ~abort_s;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        o_a_stall = i_wb_stall;
        o_a_ack   = i_wb_ack;
        o_a_err   = i_wb_err | wd_expire_s;
      end
      GNT_B: begin
        o_wb_cyc  = bus_cyc_s;
        o_wb_stb  = i_b_stb & ~abort_s;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
        o_b_stall = i_wb_stall;
        o_b_ack   = i_wb_ack;
        o_b_err   = i_wb_err | wd_expire_s;
      end
      default: begin
        o_wb_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (TIMEOUT_CYCLES = 8).
// With WB_ARB_TIMEOUT_EN defined the watchdog scenario is exercised,
// otherwise the hung-slave-holds-grant behaviour is.
module tb_wb_rr_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_a_cyc, i_a_stb, i_a_we;
  logic [29:0] i_a_addr;
  logic [31:0] i_a_data;
  logic [3:0]  i_a_sel;
  logic        o_a_stall, o_a_ack, o_a_err;
  logic [31:0] o_a_data;
  logic        i_b_cyc, i_b_stb, i_b_we;
  logic [29:0] i_b_addr;
  logic [31:0] i_b_data;
  logic [3:0]  i_b_sel;
  logic        o_b_stall, o_b_ack, o_b_err;
  logic [31:0] o_b_data;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_a_cyc = 1'b0; i_a_stb = 1'b0; i_a_we = 1'b0; i_a_addr = 30'h0; i_a_data = 32'h0; i_a_sel = 4'h0;
    i_b_cyc = 1'b0; i_b_stb = 1'b0; i_b_we = 1'b0; i_b_addr = 30'h0; i_b_data = 32'h0; i_b_sel = 4'h0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b1;
    i_wb_ack = 1'b1;
    i_wb_err = 1'b1;
    #3;
    checks++; if (o_wb_cyc !== 1'b0) begin failures++; $display("FAIL reset_wb_cyc got=%0b exp=0", o_wb_cyc); end
    checks++; if (o_wb_stb !== 1'b0) begin failures++; $display("FAIL reset_wb_stb got=%0b exp=0", o_wb_stb); end
    checks++; if (o_a_stall !== 1'b1) begin failures++; $display("FAIL reset_a_stall got=%0b exp=1", o_a_stall); end
    checks++; if (o_b_stall !== 1'b1) begin failures++; $display("FAIL reset_b_stall got=%0b exp=1", o_b_stall); end
    checks++; if (o_a_ack !== 1'b0 || o_b_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b%0b exp=00", o_a_ack, o_b_ack); end
    checks++; if (o_a_err !== 1'b0 || o_b_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b%0b exp=00", o_a_err, o_b_err); end
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_single_a();
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_we = 1'b1; i_a_addr = 30'h10;
    i_a_data = 32'hDEADBEEF; i_a_sel = 4'hF; i_wb_stall = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0) begin failures++; $display("FAIL single_idle_cyc got=%0b exp=0", o_wb_cyc); end
    checks++; if (o_a_stall !== 1'b1) begin failures++; $display("FAIL single_idle_stall got=%0b exp=1", o_a_stall); end
    step();
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1) begin failures++; $display("FAIL single_cyc_stb got=%0b%0b exp=11", o_wb_cyc, o_wb_stb); end
    checks++; if (o_wb_we !== 1'b1) begin failures++; $display("FAIL single_we got=%0b exp=1", o_wb_we); end
    checks++; if (o_wb_addr !== 30'h10) begin failures++; $display("FAIL single_addr got=%h exp=10", o_wb_addr); end
    checks++; if (o_wb_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", o_wb_data); end
    checks++; if (o_wb_sel !== 4'hF) begin failures++; $display("FAIL single_sel got=%h exp=f", o_wb_sel); end
    checks++; if (o_a_stall !== 1'b0 || o_b_stall !== 1'b1) begin failures++; $display("FAIL single_stalls got=%0b%0b exp=01", o_a_stall, o_b_stall); end
    i_wb_ack = 1'b1;
    i_wb_data = 32'h12345678;
    #1;
    checks++; if (o_a_ack !== 1'b1) begin failures++; $display("FAIL single_a_ack got=%0b exp=1", o_a_ack); end
    checks++; if (o_b_ack !== 1'b0) begin failures++; $display("FAIL single_b_ack got=%0b exp=0", o_b_ack); end
    checks++; if (o_a_data !== 32'h12345678 || o_b_data !== 32'h12345678) begin failures++; $display("FAIL single_rdata got=%h/%h exp=12345678", o_a_data, o_b_data); end
    step();
    i_wb_ack = 1'b0;
    i_a_cyc = 1'b0; i_a_stb = 1'b0;
    #1;
    checks++; if (o_wb_cyc !== 1'b0) begin failures++; $display("FAIL single_release_cyc got=%0b exp=0", o_wb_cyc); end
    step();
    checks++; if (o_a_stall !== 1'b1) begin failures++; $display("FAIL single_back_idle got=%0b exp=1", o_a_stall); end
  endtask

  task automatic test_contention();
    i_reset = 1'b1;
    #1;
    i_reset = 1'b0;
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_we = 1'b0; i_a_addr = 30'h100;
    i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_we = 1'b1; i_b_addr = 30'h200; i_b_data = 32'hB0B0B0B0;
    step();
    checks++; if (o_wb_addr !== 30'h100 || o_a_stall !== 1'b0 || o_b_stall !== 1'b1) begin failures++; $display("FAIL cont_first_a got addr=%h stalls=%0b%0b exp addr=100 stalls=01", o_wb_addr, o_a_stall, o_b_stall); end
    step();
    checks++; if (o_wb_addr !== 30'h100 || o_wb_we !== 1'b0) begin failures++; $display("FAIL cont_hold_a got addr=%h we=%0b exp addr=100 we=0", o_wb_addr, o_wb_we); end
    i_a_cyc = 1'b0; i_a_stb = 1'b0;
    step();
    checks++; if (o_wb_cyc !== 1'b0 || o_b_stall !== 1'b1) begin failures++; $display("FAIL cont_dead_cycle got cyc=%0b bstall=%0b exp cyc=0 bstall=1", o_wb_cyc, o_b_stall); end
    step();
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_addr !== 30'h200 || o_wb_we !== 1'b1) begin failures++; $display("FAIL cont_then_b got cyc=%0b addr=%h we=%0b exp cyc=1 addr=200 we=1", o_wb_cyc, o_wb_addr, o_wb_we); end
    checks++; if (o_b_stall !== 1'b0 || o_a_stall !== 1'b1) begin failures++; $display("FAIL cont_b_stalls got=%0b%0b exp=10", o_a_stall, o_b_stall); end
    i_b_cyc = 1'b0; i_b_stb = 1'b0;
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_b_cyc = 1'b1; i_b_stb = 1'b1;
    step();
    checks++; if (o_wb_addr !== 30'h100 || o_a_stall !== 1'b0 || o_b_stall !== 1'b1) begin failures++; $display("FAIL cont_second_a got addr=%h stalls=%0b%0b exp addr=100 stalls=01", o_wb_addr, o_a_stall, o_b_stall); end
    clear_inputs();
    step();
  endtask

  task automatic test_no_preempt();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_we = 1'b1; i_a_addr = 30'h300; i_a_data = 32'hA5A5A5A5;
    step();
    i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_we = 1'b0; i_b_addr = 30'h3FF; i_b_data = 32'h5A5A5A5A;
    i_wb_ack = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_b_stall !== 1'b1) begin failures++; $display("FAIL hold_b_stall[%0d] got=%0b exp=1", i, o_b_stall); end
      checks++; if (o_wb_addr !== 30'h300) begin failures++; $display("FAIL hold_addr[%0d] got=%h exp=300", i, o_wb_addr); end
      checks++; if (o_wb_we !== 1'b1 || o_wb_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL hold_we_data[%0d] got=%0b/%h exp=1/a5a5a5a5", i, o_wb_we, o_wb_data); end
      checks++; if (o_b_ack !== 1'b0 || o_a_ack !== 1'b1) begin failures++; $display("FAIL hold_acks[%0d] got=%0b%0b exp=10", i, o_a_ack, o_b_ack); end
      if (i < 4) step();
    end
    i_wb_ack = 1'b0;
    i_a_cyc = 1'b0; i_a_stb = 1'b0;
    step();
    checks++; if (o_wb_cyc !== 1'b0 || o_b_stall !== 1'b1) begin failures++; $display("FAIL hold_dead got cyc=%0b bstall=%0b exp cyc=0 bstall=1", o_wb_cyc, o_b_stall); end
    step();
    checks++; if (o_wb_addr !== 30'h3FF || o_b_stall !== 1'b0 || o_wb_we !== 1'b0) begin failures++; $display("FAIL hold_b_granted got addr=%h bstall=%0b we=%0b exp addr=3ff bstall=0 we=0", o_wb_addr, o_b_stall, o_wb_we); end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 30'h40;
    i_wb_ack = 1'b1;
    step();
    checks++; if (o_wb_cyc !== 1'b1) begin failures++; $display("FAIL rmid_pre_cyc got=%0b exp=1", o_wb_cyc); end
    i_reset = 1'b1;
    #1;
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin failures++; $display("FAIL rmid_async_cyc got=%0b%0b exp=00", o_wb_cyc, o_wb_stb); end
    checks++; if (o_a_stall !== 1'b1 || o_a_ack !== 1'b0) begin failures++; $display("FAIL rmid_async_resp got stall=%0b ack=%0b exp stall=1 ack=0", o_a_stall, o_a_ack); end
    clear_inputs();
    #1;
    i_reset = 1'b0;
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 30'h40;
    i_b_cyc = 1'b1; i_b_stb = 1'b1; i_b_addr = 30'h80;
    step();
    checks++; if (o_wb_addr !== 30'h40 || o_a_stall !== 1'b0) begin failures++; $display("FAIL rmid_a_wins got addr=%h astall=%0b exp addr=40 astall=0", o_wb_addr, o_a_stall); end
    clear_inputs();
    step();
  endtask

  task automatic test_err();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 30'h50;
    step();
    i_wb_err = 1'b1;
    #1;
    checks++; if (o_a_err !== 1'b1 || o_b_err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%0b%0b exp=10", o_a_err, o_b_err); end
    step();
    i_wb_err = 1'b0;
    #1;
    checks++; if (o_a_err !== 1'b0) begin failures++; $display("FAIL err_once got=%0b exp=0", o_a_err); end
    checks++; if (o_wb_cyc !== 1'b1 || o_wb_addr !== 30'h50) begin failures++; $display("FAIL err_grant_kept got cyc=%0b addr=%h exp cyc=1 addr=50", o_wb_cyc, o_wb_addr); end
    step();
    checks++; if (o_wb_cyc !== 1'b1 || o_a_err !== 1'b0) begin failures++; $display("FAIL err_grant_kept2 got cyc=%0b err=%0b exp cyc=1 err=0", o_wb_cyc, o_a_err); end
    clear_inputs();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic exp_err;
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 30'h60;
    i_wb_stall = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      exp_err = (k == 8) ? 1'b1 : 1'b0;
      checks++; if (o_a_err !== exp_err) begin failures++; $display("FAIL wd_err[%0d] got=%0b exp=%0b", k, o_a_err, exp_err); end
      checks++; if (o_wb_cyc !== 1'b1) begin failures++; $display("FAIL wd_cyc[%0d] got=%0b exp=1", k, o_wb_cyc); end
      if (k < 8) step();
    end
    step();
    checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_a_err !== 1'b0) begin failures++; $display("FAIL wd_abort got cyc=%0b stb=%0b err=%0b exp 000", o_wb_cyc, o_wb_stb, o_a_err); end
    step();
    checks++; if (o_wb_cyc !== 1'b0) begin failures++; $display("FAIL wd_abort_hold got=%0b exp=0", o_wb_cyc); end
    clear_inputs();
    step();
    i_a_cyc = 1'b1; i_a_stb = 1'b1;
    step();
    checks++; if (o_wb_cyc !== 1'b1) begin failures++; $display("FAIL wd_abort_cleared got=%0b exp=1", o_wb_cyc); end
    clear_inputs();
    step();
  endtask
`else
  task automatic test_hung_slave();
    i_a_cyc = 1'b1; i_a_stb = 1'b1; i_a_addr = 30'h60;
    i_wb_stall = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      checks++; if (o_wb_cyc !== 1'b1 || o_a_err !== 1'b0) begin failures++; $display("FAIL hung_hold[%0d] got cyc=%0b err=%0b exp cyc=1 err=0", k, o_wb_cyc, o_a_err); end
      step();
    end
    clear_inputs();
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL tb_time_limit expired at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    clear_inputs();
    i_reset = 1'b1;
    test_reset();
    test_single_a();
    test_contention();
    test_no_preempt();
    test_reset_mid();
    test_err();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hung_slave();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
